// File: rtl/mac_array.sv
`timescale 1ns/1ps
// mac_array: LANES parallel fixed-point MAC lanes sharing one broadcast operand.
// Full-precision accumulate per vector, then round half-up, saturate, optional ReLU.
module mac_array #(
    parameter int LANES     = 4,
    parameter int Q_INT     = 8,
    parameter int Q_FRAC    = 8,
    parameter int ACC_GUARD = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic                     mode_square,
    input  logic                     relu_en,
    input  logic [Q_INT+Q_FRAC-1:0]  x,
    input  logic [LANES*(Q_INT+Q_FRAC)-1:0] w,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*(Q_INT+Q_FRAC)-1:0] out_data,
    output logic [LANES-1:0]         out_sat
);

    localparam int W  = Q_INT + Q_FRAC;
    localparam int PW = 2 * W;
    localparam int AW = PW + ACC_GUARD;
    localparam int RW = AW + 1;

    localparam logic signed [RW-1:0] MAX_V = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {ST_ACC, ST_FLUSH, ST_OUT} state_t;

    state_t                state;
    logic                  first;
    logic                  p_valid;
    logic                  p_last;
    logic                  p_relu;
    logic                  accept;
    logic                  fin;
    logic signed [PW-1:0]  prod_c   [LANES];
    logic signed [PW-1:0]  p_prod   [LANES];
    logic signed [AW-1:0]  acc      [LANES];
    logic signed [AW-1:0]  acc_next [LANES];
    logic signed [RW-1:0]  rnd      [LANES];
    logic signed [RW-1:0]  shf      [LANES];
    logic [LANES*W-1:0]    fin_data;
    logic [LANES-1:0]      fin_sat;

    // in_ready depends on state alone so the source never sees a combinational loop.
    assign in_ready = (state == ST_ACC);
    assign accept   = in_valid & in_ready;
    assign fin      = p_valid & p_last;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_c[i] = PW'($signed(x)) * PW'($signed(mode_square ? x : w[i*W +: W]));
        end
    end

    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        fin_data = '0;
        fin_sat  = '0;
        for (int i = 0; i < LANES; i++) begin
            acc_next[i] = (first ? '0 : acc[i]) + {{ACC_GUARD{p_prod[i][PW-1]}}, p_prod[i]};
            rnd[i]      = {acc_next[i][AW-1], acc_next[i]} + (RW'(1) << (Q_FRAC - 1));
            shf[i]      = rnd[i] >>> Q_FRAC;
            if (shf[i] > MAX_V) begin
                fin_data[i*W +: W] = MAX_V[W-1:0];
                fin_sat[i]         = 1'b1;
            end else if (shf[i] < MIN_V) begin
                fin_data[i*W +: W] = MIN_V[W-1:0];
                fin_sat[i]         = 1'b1;
            end else begin
                fin_data[i*W +: W] = shf[i][W-1:0];
            end
            if (p_relu && fin_data[i*W + W - 1]) begin
                fin_data[i*W +: W] = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ACC;
            first     <= 1'b1;
            p_valid   <= 1'b0;
            p_last    <= 1'b0;
            p_relu    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
            // NOTE: the small accumulator array is reset so a reset mid-vector leaves no stale partial sum.
            for (int i = 0; i < LANES; i++) begin
                p_prod[i] <= '0;
                acc[i]    <= '0;
            end
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_last <= in_last;
                p_relu <= relu_en;
                for (int i = 0; i < LANES; i++) begin
                    p_prod[i] <= prod_c[i];
                end
            end

            if (p_valid) begin
                first <= p_last;
                for (int i = 0; i < LANES; i++) begin
                    acc[i] <= acc_next[i];
                end
            end

            if (fin) begin
                out_data <= fin_data;
                out_sat  <= fin_sat;
            end

            case (state)
                ST_ACC: begin
                    if (accept && in_last) state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (fin) state <= ST_OUT;
                end
                ST_OUT: begin
                    // Result was registered on entry; valid rises one cycle later and holds until taken.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACC;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: doc/mac_array.md
# mac_array

Parametrised, pipelined multi-lane fixed-point multiply-accumulate engine for the neural-network datapath. One input x is broadcast to LANES lanes. Each lane multiplies x by its own weight, or by x itself in square mode, and accumulates at full precision over a vector terminated by in_last. Each lane's sum is rounded, saturated, optionally passed through ReLU, and presented on a valid/ready output held until consumed. This block replaces the single-lane MAC with lane-parallel, handshaked dot-product evaluation for neuron layers.

## Interface
- LANES, 4, number of parallel MAC lanes (≥1)
- Q_INT, 8, integer bits of signed fixed-point operands/results (incl. sign)
- Q_FRAC, 8, fractional bits (≥1); W = Q_INT+Q_FRAC
- ACC_GUARD, 8, extra integer guard bits in accumulator

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_last  in  1  beat is last of vector
- mode_square  in  1  1: lane product = x*x; 0: x*w[lane]
- relu_en  in  1  apply ReLU to result (sampled with last beat)
- x  in  W  broadcast signed operand
- w  in  LANES*W  lane i weight at [i*W +: W], signed
- out_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- out_data  out  LANES*W  lane i result at [i*W +: W]
- out_sat  out  LANES  lane i result was saturated

## Operation
- Accept = in_valid & in_ready. x, w, mode_square, in_last, relu_en are sampled only on accept.
- Stage P (product): on accept, p_prod[i] <= signed 2W-bit full product and p_valid <= 1, latching p_last and p_relu. Without accept, p_valid <= 0.
- Stage A (accumulate): acc[i] is 2W+ACC_GUARD bits wide, with 2*Q_FRAC fractional bits. If p_valid, acc[i] <= (first ? 0 : acc[i]) + sign-extended p_prod[i]. first is set at reset and after each completed vector, and cleared by the first accumulated beat. Accumulator overflow beyond the guard bits wraps (two's complement), unflagged.
- Finalisation, on the p_valid & p_last cycle, using sum = new accumulator value:
  - Round half-up: add 2^(Q_FRAC-1), then arithmetic shift right by Q_FRAC.
  - Saturate to [-2^(W-1), 2^(W-1)-1]. out_sat[i] = 1 if clamped.
  - If p_relu, negative results become 0. out_sat is unchanged by ReLU.
  - Register the result into out_data/out_sat.
- States:
  - ACC: in_ready = 1. Accept with in_last -> FLUSH.
  - FLUSH: in_ready = 0. Last product is accumulated and the result registered -> OUT.
  - OUT: out_valid = 1, in_ready = 0. out_valid & out_ready -> ACC, out_valid drops next cycle.
- out_data/out_sat are stable for the whole OUT state regardless of out_ready.
- A single-beat vector (in_last on the first beat) is legal.
- mode_square may change per beat; each product uses the value sampled with its beat.

## Timing
- Reset (async, immediate): state = ACC, first = 1, p_valid = 0, acc = 0, out_valid = 0, out_data = 0, out_sat = 0. in_ready = 1 after reset deasserts.
- Reset mid-vector or in OUT discards the partial sum and any pending result.
- Latency: accept of the last beat at edge k gives out_valid = 1 after edge k+2.
- Throughput: 1 beat/cycle within a vector. A vector of L beats occupies L+2 cycles plus output-hold cycles.
- Earliest next-vector accept is the cycle after the out_valid & out_ready edge. in_ready is combinational from state only, with no dependence on in_valid or out_ready.
- in_valid while in_ready = 0 is ignored; the source holds the beat.

## Test plan
- LANES=4, Q8.8, single beat x=0x0200, w={0x0100,0x0180,0xFF00,0x0000}, last=1 -> out_data lanes {0x0200,0x0300,0xFE00,0x0000}, out_sat=0, out_valid 2 cycles after accept.
- Three beats x=0x0100, w=0x0100 all lanes, back-to-back, last on beat 3 -> all lanes 0x0300. Next vector (one beat x=0x0100, w=0x0100) -> 0x0100, proving the accumulator cleared.
- Saturation: x=0x7F00, w=0x0200 -> 0x7FFF, out_sat=1. w=0xFE00 -> 0x8000, out_sat=1. With relu_en=1 and w=0xFE00 -> 0x0000, out_sat=1.
- Rounding: x=0x0001, w=0x0080 -> 0x0001. x=0xFFFF, w=0x0080 -> 0x0000. x=0x0001, w=0x007F -> 0x0000.
- Backpressure and square mode: out_ready low 5 cycles -> out_data stable, in_ready=0, in_valid beats ignored. Square mode x=0xFE00 -> all lanes 0x0400 regardless of w.
- Assert reset after 2 of 4 beats, release, send one-beat vector x=w=0x0100 -> result 0x0100, no stale sum, out_valid=0 during reset.
